// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, op encoding and default widths for mem_arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one line-wide memory port between I- and D-cache
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              owner_d
);

    arb_state_t        r_state;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata_q;
    logic              r_i_ready;
    logic              r_d_ready;
    logic              r_owner_d;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_d;
    mem_op_t           w_op;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_i_req = i_read | i_write;
    assign w_d_req = d_read | d_write;

    // On contention the port that did not own the previous transaction wins.
    assign w_grant_d = w_d_req & (~w_i_req | ~r_owner_d);

    // Write wins when a cache raises read and write together.
    assign w_op    = (w_grant_d ? d_write : i_write) ? OP_WRITE : OP_READ;
    assign w_addr  = w_grant_d ? d_addr  : i_addr;
    assign w_wdata = w_grant_d ? d_wdata : i_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata_q   <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_owner_d   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_i_req | w_d_req) begin
                        r_mem_read  <= (w_op == OP_READ);
                        r_mem_write <= (w_op == OP_WRITE);
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_owner_d   <= w_grant_d;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Requester inputs are deliberately not looked at here.
                    if (mem_ready) begin
                        r_rdata_q   <= mem_rdata;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_i_ready   <= ~r_owner_d;
                        r_d_ready   <= r_owner_d;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_i_ready <= 1'b0;
                    r_d_ready <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_ready   = r_i_ready;
    assign d_ready   = r_d_ready;
    assign i_rdata   = r_rdata_q;
    assign d_rdata   = r_rdata_q;
    assign owner_d   = r_owner_d;
    assign busy      = (r_state != IDLE);

endmodule
